// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction word, fetch bubble encoding and
// the instruction-queue control states.
package cpu_pkg;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] instr_t;

  localparam instr_t INSTR_BUBBLE = '0;

  typedef enum logic [1:0] {
    IQ_RUN,
    IQ_DRAIN,
    IQ_DONE
  } iq_state_e;
endpackage

// File: rtl/iq_storage.sv
// Instruction queue storage: DEPTH x XLEN register array with two write ports
// and two asynchronous read ports (head and head+1). Contents are not reset.
module iq_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  instr_t        wdata1,
  input  logic          we2,
  input  logic [AW-1:0] waddr2,
  input  instr_t        wdata2,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output instr_t        rdata1,
  output instr_t        rdata2
);

  instr_t mem [DEPTH];

  // The two write addresses are always distinct when both ports are enabled.
  always_ff @(posedge clk) begin
    if (we1) mem[waddr1] <= wdata1;
    if (we2) mem[waddr2] <= wdata2;
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/instr_queue.sv
// Dual-issue instruction queue between fetch and decode: squashes fetch bubbles,
// keeps program order, and turns fetch's finish into a drained indication.
module instr_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  instr_t                   in_instr1,
  input  instr_t                   in_instr2,
  input  logic                     in_valid1,
  input  logic                     in_valid2,
  input  logic                     in_finish,
  output logic                     in_ready,
  output instr_t                   out_instr1,
  output instr_t                   out_instr2,
  output logic                     out_valid1,
  output logic                     out_valid2,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] tail_plus1;
  logic [AW-1:0] waddr2;
  logic [AW-1:0] head_plus1;
  logic [CW-1:0] count_next;
  logic [1:0]    n_enq;
  logic [1:0]    n_deq;
  logic          acc1;
  logic          acc2;
  instr_t        rdata1;
  instr_t        rdata2;
  iq_state_e     state;
  iq_state_e     state_next;

  // Free space is judged on the current count so in_ready never depends on out_ready.
  assign in_ready = (state == IQ_RUN) && (count <= CW'(DEPTH - 2));

  assign acc1 = in_ready && in_valid1 && (in_instr1 != INSTR_BUBBLE);
  assign acc2 = in_ready && in_valid2 && (in_instr2 != INSTR_BUBBLE);
  assign n_enq = {1'b0, acc1} + {1'b0, acc2};

  assign out_valid1 = (count != '0);
  assign out_valid2 = (count > CW'(1));

  always_comb begin
    n_deq = 2'd0;
    if (out_ready) begin
      if (out_valid2)      n_deq = 2'd2;
      else if (out_valid1) n_deq = 2'd1;
    end
  end

  assign count_next = count + CW'(n_enq) - CW'(n_deq);

  assign tail_plus1 = tail + AW'(1);
  assign waddr2     = acc1 ? tail_plus1 : tail;
  assign head_plus1 = head + AW'(1);

  iq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk    (clk),
    .we1    (acc1),
    .waddr1 (tail),
    .wdata1 (in_instr1),
    .we2    (acc2),
    .waddr2 (waddr2),
    .wdata2 (in_instr2),
    .raddr1 (head),
    .raddr2 (head_plus1),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  assign out_instr1 = out_valid1 ? rdata1 : INSTR_BUBBLE;
  assign out_instr2 = out_valid2 ? rdata2 : INSTR_BUBBLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_deq);
      tail  <= tail + AW'(n_enq);
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IQ_RUN;
    else        state <= state_next;
  end

  // A pair presented alongside finish is still taken; afterwards only draining happens.
  always_comb begin
    state_next = state;
    case (state)
      IQ_RUN: begin
        if (in_finish) state_next = (count_next == '0) ? IQ_DONE : IQ_DRAIN;
      end
      IQ_DRAIN: begin
        if (count_next == '0) state_next = IQ_DONE;
      end
      IQ_DONE:  state_next = IQ_DONE;
      default:  state_next = IQ_RUN;
    endcase
  end

  assign drained = (state == IQ_DONE);

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: a reference queue of expected words is
// filled on accepted enqueues and drained as decode pops them.
module tb_instr_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  instr_t      in_instr1, in_instr2;
  logic        in_valid1, in_valid2, in_finish;
  logic        in_ready;
  instr_t      out_instr1, out_instr2;
  logic        out_valid1, out_valid2;
  logic        out_ready;
  logic [3:0]  count;
  logic        drained;

  int n_checks = 0;
  int n_fail   = 0;

  instr_t exp_q[$];
  int     m_state;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_instr1  (in_instr1),
    .in_instr2  (in_instr2),
    .in_valid1  (in_valid1),
    .in_valid2  (in_valid2),
    .in_finish  (in_finish),
    .in_ready   (in_ready),
    .out_instr1 (out_instr1),
    .out_instr2 (out_instr2),
    .out_valid1 (out_valid1),
    .out_valid2 (out_valid2),
    .out_ready  (out_ready),
    .count      (count),
    .drained    (drained)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Compare every DUT output against the reference queue and reference state.
  task automatic checkModel();
    int sz;
    sz = exp_q.size();
    checkOutput("count", 32'(count), 32'(sz));
    checkOutput("out_valid1", 32'(out_valid1), 32'(sz >= 1));
    checkOutput("out_valid2", 32'(out_valid2), 32'(sz >= 2));
    checkOutput("out_instr1", out_instr1, (sz >= 1) ? exp_q[0] : 32'h0);
    checkOutput("out_instr2", out_instr2, (sz >= 2) ? exp_q[1] : 32'h0);
    checkOutput("in_ready", 32'(in_ready), 32'((m_state == 0) && ((DEPTH - sz) >= 2)));
    checkOutput("drained", 32'(drained), 32'(m_state == 2));
  endtask

  // One clock cycle: drive inputs, check current outputs, clock, update the reference.
  task automatic applyStimulus(input logic v1, input instr_t i1, input logic v2, input instr_t i2,
                               input logic fin, input logic ordy);
    bit rdy;
    int ndeq;
    in_valid1 = v1;
    in_instr1 = i1;
    in_valid2 = v2;
    in_instr2 = i2;
    in_finish = fin;
    out_ready = ordy;
    checkModel();
    rdy  = (m_state == 0) && ((DEPTH - exp_q.size()) >= 2);
    ndeq = ordy ? ((exp_q.size() >= 2) ? 2 : exp_q.size()) : 0;
    @(posedge clk);
    #1;
    repeat (ndeq) void'(exp_q.pop_front());
    if (rdy) begin
      if (v1 && i1 != 32'h0) exp_q.push_back(i1);
      if (v2 && i2 != 32'h0) exp_q.push_back(i2);
    end
    if (m_state == 0 && fin)                    m_state = (exp_q.size() == 0) ? 2 : 1;
    else if (m_state == 1 && exp_q.size() == 0) m_state = 2;
  endtask

  task automatic asyncReset();
    #3;
    in_valid1 = 1'b0; in_valid2 = 1'b0; in_finish = 1'b0; out_ready = 1'b0;
    in_instr1 = '0;   in_instr2 = '0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_state = 0;
    checkModel();
    @(posedge clk);
    #1;
    checkModel();
    rst_n = 1'b1;
  endtask

  initial begin
    instr_t r1, r2;
    rst_n = 1'b0;
    in_valid1 = 1'b0; in_valid2 = 1'b0; in_finish = 1'b0; out_ready = 1'b0;
    in_instr1 = '0;   in_instr2 = '0;
    m_state = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    $display("[TB] basic pair");
    applyStimulus(1, 32'h00500093, 1, 32'h00A00113, 0, 0);
    checkOutput("t2_count", 32'(count), 32'd2);
    checkOutput("t2_instr1", out_instr1, 32'h00500093);
    checkOutput("t2_instr2", out_instr2, 32'h00A00113);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t2_count_pop", 32'(count), 32'd0);

    $display("[TB] fill and wrap");
    for (int k = 0; k < 4; k++)
      applyStimulus(1, 32'h1000_0000 + 32'(2 * k), 1, 32'h1000_0001 + 32'(2 * k), 0, 0);
    checkOutput("t3_full_count", 32'(count), 32'd8);
    checkOutput("t3_full_ready", 32'(in_ready), 32'd0);
    applyStimulus(1, 32'hDEAD0001, 1, 32'hDEAD0002, 0, 0);
    checkOutput("t3_held_count", 32'(count), 32'd8);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t3_pop_ready", 32'(in_ready), 32'd1);
    checkOutput("t3_pop_count", 32'(count), 32'd6);
    for (int k = 0; k < 4; k++)
      applyStimulus(1, 32'h2000_0000 + 32'(2 * k), 1, 32'h2000_0001 + 32'(2 * k), 0, 1'(k % 2));
    repeat (8) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t3_empty", 32'(count), 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(1, 32'h3000_0001, 1, 32'h3000_0002, 0, 0);
    asyncReset();

    $display("[TB] bubbles");
    applyStimulus(1, 32'h002081B3, 1, 32'h0, 0, 0);
    checkOutput("t4_count", 32'(count), 32'd1);
    applyStimulus(0, 0, 1, 32'h40208233, 0, 0);
    checkOutput("t4_instr1", out_instr1, 32'h002081B3);
    checkOutput("t4_instr2", out_instr2, 32'h40208233);

    $display("[TB] simultaneous enqueue and dequeue");
    applyStimulus(1, 32'h00300193, 0, 0, 0, 0);
    checkOutput("t5_count_pre", 32'(count), 32'd3);
    applyStimulus(1, 32'h00400213, 1, 32'h00500293, 0, 1);
    checkOutput("t5_count_post", 32'(count), 32'd3);
    checkOutput("t5_head", out_instr1, 32'h00300193);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] random traffic");
    repeat (60) begin
      r1 = ($urandom_range(0, 3) == 0) ? 32'h0 : instr_t'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? 32'h0 : instr_t'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), r1, 1'($urandom_range(0, 1)), r2, 0,
                    1'($urandom_range(0, 2) == 0));
    end
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] finish and drain");
    applyStimulus(1, 32'h00100073, 1, 32'h00200073, 0, 0);
    applyStimulus(1, 32'h00300073, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("t6_ready", 32'(in_ready), 32'd0);
    checkOutput("t6_count", 32'(count), 32'd3);
    applyStimulus(1, 32'h0BAD0001, 1, 32'h0BAD0002, 1, 0);
    checkOutput("t6_ignored", 32'(count), 32'd3);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t6_pop2", 32'(count), 32'd1);
    checkOutput("t6_not_drained", 32'(drained), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t6_empty", 32'(count), 32'd0);
    checkOutput("t6_drained", 32'(drained), 32'd1);
    repeat (3) applyStimulus(1, 32'h0BAD0003, 1, 32'h0BAD0004, 1, 1);
    checkOutput("t6_drained_hold", 32'(drained), 32'd1);
    asyncReset();
    checkOutput("t6_drained_reset", 32'(drained), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
